psum_drain_ctrl: RTL and testbench

Downstream of the partial-sum accumulator controller. It drains the finished packed partial sums from the shared psum memory once a convolution pass completes. Each memory word holds NUM_KERNEL lanes of BIT_WIDTH. Words are read sequentially from a base address and streamed out on a valid/ready interface toward the output writer. A credit-based skid FIFO absorbs memory read latency, so backpressure never drops data.

---
 rtl/psum_drain_ctrl.sv | 163 ++++++++++++++++
 tb/tb_psum_drain_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_ctrl.sv
// rtl/psum_drain_ctrl.sv - drains packed partial sums from psum memory onto a valid/ready stream
// Optional lane ReLU clamp on the FIFO write path: define PSUM_DRAIN_RELU_EN.
module psum_drain_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int DATA_WIDTH = BIT_WIDTH * NUM_KERNEL,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MEM_DELAY  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [REG_WIDTH-1:0]  i_num_words,
    output logic [ADDR_WIDTH-1:0] mem_radd,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    input  logic                  mem_ovld,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [REG_WIDTH-1:0]  dbg_drain_rd_cnt,
    output logic [REG_WIDTH-1:0]  dbg_drain_wr_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(MEM_DELAY + 1) + 1;
    localparam logic [CW:0]   DEPTH_V    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(MEM_DELAY);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [REG_WIDTH-1:0]    cnt_q;
    logic [REG_WIDTH-1:0]    rd_cnt;
    logic [REG_WIDTH-1:0]    wr_cnt;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           fifo_cnt;
    logic [CW-1:0]           outstanding;
    logic [FW-1:0]           flush_cnt;

    logic                    active;
    logic                    credit_ok;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   push_dat;

`ifdef PSUM_DRAIN_RELU_EN
    function automatic logic [DATA_WIDTH-1:0] relu_clamp(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if (w[BIT_WIDTH*(k+1)-1])
                r[BIT_WIDTH*k +: BIT_WIDTH] = '0;
        end
        return r;
    endfunction
    assign push_dat = relu_clamp(mem_odat);
`else
    assign push_dat = mem_odat;
`endif

    // Credits cover both in-flight reads and buffered words, so a response always has a slot.
    assign active    = (state == S_READ) || (state == S_DRAIN);
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_V;
    assign mem_rden  = (state == S_READ) && (rd_cnt < cnt_q) && credit_ok;
    assign mem_radd  = mem_rden ? base_q + ADDR_WIDTH'(rd_cnt) : '0;
    assign push      = mem_ovld && active && (flush_cnt == '0);
    assign o_vld     = (fifo_cnt != '0);
    assign o_dat     = fifo_mem[rd_ptr];
    assign pop       = o_vld && i_rdy && active && (wr_cnt < cnt_q);

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign dbg_drain_rd_cnt = rd_cnt;
    assign dbg_drain_wr_cnt = wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            flush_cnt   <= FLUSH_INIT;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else begin
            // Responses to reads issued before reset are still in the memory pipe.
            if (flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);
            if (push) begin
                fifo_mem[wr_ptr] <= push_dat;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(mem_rden) - CW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            base_q <= '0;
            cnt_q  <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (mem_rden)
                rd_cnt <= rd_cnt + REG_WIDTH'(1);
            if (pop)
                wr_cnt <= wr_cnt + REG_WIDTH'(1);
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start && (flush_cnt == '0)) begin
                        busy_q <= 1'b1;
                        base_q <= i_base_addr;
                        cnt_q  <= i_num_words;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= (i_num_words == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (rd_cnt == cnt_q)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && (wr_cnt + REG_WIDTH'(1) == cnt_q)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Zero-count runs arrive here with the pulse not yet raised.
                    if (done_q) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb/tb_psum_drain_ctrl.sv - directed self-checking bench for psum_drain_ctrl
module tb_psum_drain_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_num_words;
    logic [31:0] mem_radd;
    logic        mem_rden;
    logic [31:0] mem_odat;
    logic        mem_ovld;
    logic [31:0] o_dat;
    logic        o_vld;
    logic        i_rdy;
    logic        o_busy;
    logic        o_done;
    logic [31:0] dbg_drain_rd_cnt;
    logic [31:0] dbg_drain_wr_cnt;

    always #5 clk = ~clk;

    psum_drain_ctrl dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_words(i_num_words), .mem_radd(mem_radd), .mem_rden(mem_rden),
        .mem_odat(mem_odat), .mem_ovld(mem_ovld), .o_dat(o_dat), .o_vld(o_vld),
        .i_rdy(i_rdy), .o_busy(o_busy), .o_done(o_done),
        .dbg_drain_rd_cnt(dbg_drain_rd_cnt), .dbg_drain_wr_cnt(dbg_drain_wr_cnt)
    );

    // Two-stage read pipe: fixed two-cycle latency, word = 0x04030201 + addr.
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_a = '0, p2_a = '0;
    logic        relu_mode = 1'b0;
    always @(posedge clk) begin
        p1_v <= mem_rden;
        p1_a <= mem_radd;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_ovld = p2_v;
    assign mem_odat = relu_mode ? 32'h80FF7F01 : 32'h04030201 + p2_a;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] addr_q[$];
    int          rden_cyc_q[$];
    logic [31:0] beat_q[$];
    int          beat_cyc_q[$];
    int          first_vld, done_cyc, busy_cyc, max_infl;

    // Cycle 0 is the cycle that carries i_start; runs until o_done or the limit.
    task automatic run(input logic [31:0] base, input logic [31:0] num, input int rdy_mode,
                       input int extra_t, input int limit);
        int t, rd, wr;
        bit fin;
        addr_q.delete(); rden_cyc_q.delete(); beat_q.delete(); beat_cyc_q.delete();
        first_vld = -1; done_cyc = -1; busy_cyc = 0; max_infl = 0;
        t = 0; rd = 0; wr = 0; fin = 1'b0;
        while (!fin && t < limit) begin
            i_rdy       = (rdy_mode == 0) ? 1'b1 : ((t % 4 == 0) || (t % 4 == 3));
            i_start     = (t == 0) || (t == extra_t);
            i_base_addr = (t == 0) ? base : 32'h0000_0100;
            i_num_words = (t == 0) ? num : 32'd9;
            #1;
            if (mem_rden) begin addr_q.push_back(mem_radd); rden_cyc_q.push_back(t); rd++; end
            if (o_vld && i_rdy) begin beat_q.push_back(o_dat); beat_cyc_q.push_back(t); wr++; end
            if (rd - wr > max_infl) max_infl = rd - wr;
            if (o_vld && first_vld < 0) first_vld = t;
            if (o_busy) busy_cyc++;
            if (o_done) begin done_cyc = t; fin = 1'b1; end
            @(posedge clk); #1;
            t++;
        end
        i_start = 1'b0;
        i_rdy   = 1'b1;
        check("run_completes", fin, 1);
    endtask

    logic [31:0] wrap_addr [4];

    initial begin
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_words = '0; i_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", mem_rden, 0);
        check("rst_radd", mem_radd, 0);
        check("rst_vld", o_vld, 0);
        check("rst_dat", o_dat, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rdcnt", dbg_drain_rd_cnt, 0);
        check("rst_wrcnt", dbg_drain_wr_cnt, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Basic: 8 words from 0x10, ready held high.
        run(32'h10, 32'd8, 0, -1, 100);
        check("basic_nreads", addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("basic_addr", addr_q[i], 32'h10 + i);
            check("basic_rden_cyc", rden_cyc_q[i], 1 + i);
            check("basic_beat", beat_q[i], 32'h04030211 + i);
        end
        check("basic_first_vld", first_vld, 4);
        check("basic_done_cyc", done_cyc, 12);
        check("basic_done_after_last", done_cyc, beat_cyc_q[7] + 1);
        check("basic_rdcnt", dbg_drain_rd_cnt, 8);
        check("basic_wrcnt", dbg_drain_wr_cnt, 8);
        check("basic_idle_busy", o_busy, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: ready pattern 1,0,0,1.
        run(32'h0, 32'd16, 1, -1, 300);
        check("bp_nbeats", beat_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check("bp_beat", beat_q[i], 32'h04030201 + i);
        check("bp_inflight_le4", max_infl <= 4, 1);
        check("bp_wrcnt", dbg_drain_wr_cnt, 16);
        check("bp_done_after_last", done_cyc, beat_cyc_q[15] + 1);
        repeat (2) @(posedge clk);
        #1;

        // Zero count.
        run(32'h50, 32'd0, 0, -1, 20);
        check("zero_nreads", addr_q.size(), 0);
        check("zero_done_cyc", done_cyc, 2);
        check("zero_busy_cycles", busy_cyc, 1);
        repeat (2) @(posedge clk);
        #1;

        // Address wrap with a second start at cycle 3 that must be ignored.
        wrap_addr[0] = 32'hFFFFFFFE; wrap_addr[1] = 32'hFFFFFFFF;
        wrap_addr[2] = 32'h00000000; wrap_addr[3] = 32'h00000001;
        run(32'hFFFFFFFE, 32'd4, 0, 3, 60);
        check("wrap_nreads", addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("wrap_addr", addr_q[i], wrap_addr[i]);
        check("wrap_beat0", beat_q[0], 32'h040301FF);
        check("wrap_beat2", beat_q[2], 32'h04030201);
        check("wrap_nbeats", beat_q.size(), 4);
        check("wrap_rdcnt", dbg_drain_rd_cnt, 4);
        check("wrap_wrcnt", dbg_drain_wr_cnt, 4);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_stays_idle", o_busy, 0);

        // Reset with two reads in flight; a start inside the flush window is ignored.
        i_base_addr = 32'h40; i_num_words = 32'd8; i_start = 1'b1; i_rdy = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        check("rstmid_rden_before", mem_rden, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_start = 1'b1; i_num_words = 32'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("rstmid_start_ignored", o_busy, 0);
        for (int i = 0; i < 5; i++) begin
            check("rstmid_vld", o_vld, 0);
            @(posedge clk); #1;
        end
        check("rstmid_wrcnt", dbg_drain_wr_cnt, 0);
        run(32'h20, 32'd3, 0, -1, 50);
        check("rstmid_nbeats", beat_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("rstmid_beat", beat_q[i], 32'h04030221 + i);
        repeat (2) @(posedge clk);
        #1;

        // Lane clamp: a single negative-laned word.
        relu_mode = 1'b1;
        run(32'h60, 32'd1, 0, -1, 30);
`ifdef PSUM_DRAIN_RELU_EN
        check("relu_beat", beat_q[0], 32'h00007F01);
`else
        check("relu_beat", beat_q[0], 32'h80FF7F01);
`endif
        relu_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
